// File: rtl/qkv_pkg.sv
// qkv_pkg: definitions shared by the Q/K/V output serializer.
//   SEL_Q/SEL_K/SEL_V : encodings driven on out_sel.
//   qkv_beats()       : number of beats in one Q/K/V vector set.
package qkv_pkg;

    localparam logic [1:0] SEL_Q = 2'd0;
    localparam logic [1:0] SEL_K = 2'd1;
    localparam logic [1:0] SEL_V = 2'd2;

    function automatic int qkv_beats(input int pe_num);
        return 3 * pe_num;
    endfunction

endpackage

// File: rtl/qkv_stream_out_if.sv
// qkv_stream_out_if: capture side and streaming side of the Q/K/V serializer.
//   in_valid, in_q/in_k/in_v, in_ready : parallel capture (single-cycle pulse)
//   overflow, clear_ovf                : sticky drop flag and its clear
//   out_valid/out_ready                : streaming handshake
//   out_data, out_sel, out_idx,
//   out_last                           : current beat payload and position
// master = producer/consumer environment, slave = the serializer.
interface qkv_stream_out_if #(
    parameter int PE_NUM = 12,
    parameter int DW     = 4
);
    localparam int IW = $clog2(PE_NUM);

    logic                   in_valid;
    logic signed [2*DW-1:0] in_q [0:PE_NUM-1];
    logic signed [2*DW-1:0] in_k [0:PE_NUM-1];
    logic signed [2*DW-1:0] in_v [0:PE_NUM-1];
    logic                   in_ready;
    logic                   overflow;
    logic                   clear_ovf;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [2*DW-1:0] out_data;
    logic [1:0]             out_sel;
    logic [IW-1:0]          out_idx;
    logic                   out_last;

    modport master (
        output in_valid, in_q, in_k, in_v, clear_ovf, out_ready,
        input  in_ready, overflow, out_valid, out_data, out_sel, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_q, in_k, in_v, clear_ovf, out_ready,
        output in_ready, overflow, out_valid, out_data, out_sel, out_idx, out_last
    );

endinterface

// File: rtl/qkv_pingpong_buf.sv
// qkv_pingpong_buf: two storage entries, each holding one Q/K/V vector set.
//   clk, rst_n          : clock, async active-low reset (clears contents)
//   wr_en, wr_buf       : write all 3*PE_NUM elements into entry wr_buf
//   wr_q, wr_k, wr_v    : element vectors to write
//   rd_buf, rd_sel,
//   rd_idx, rd_data     : combinational read of one element
module qkv_pingpong_buf
    import qkv_pkg::*;
#(
    parameter int PE_NUM = 12,
    parameter int DW     = 4,
    localparam int IW    = $clog2(PE_NUM)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic                   wr_buf,
    input  logic signed [2*DW-1:0] wr_q [0:PE_NUM-1],
    input  logic signed [2*DW-1:0] wr_k [0:PE_NUM-1],
    input  logic signed [2*DW-1:0] wr_v [0:PE_NUM-1],
    input  logic                   rd_buf,
    input  logic [1:0]             rd_sel,
    input  logic [IW-1:0]          rd_idx,
    output logic signed [2*DW-1:0] rd_data
);
    typedef logic signed [2*DW-1:0] elem_t;

    // [entry][Q/K/V][head]
    elem_t mem_q [2][3][PE_NUM];
    elem_t mem_d [2][3][PE_NUM];

    // NOTE: start from the held value so every path assigns mem_d; a missing
    // default in always_comb would infer a latch.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int p = 0; p < PE_NUM; p++) begin
                mem_d[wr_buf][SEL_Q][p] = wr_q[p];
                mem_d[wr_buf][SEL_K][p] = wr_k[p];
                mem_d[wr_buf][SEL_V][p] = wr_v[p];
            end
        end
    end

    // NOTE: storage is reset so a cleared entry never shows stale data; this
    // costs reset fan-out and would be dropped if the contents could stay X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int s = 0; s < 3; s++)
                    for (int p = 0; p < PE_NUM; p++)
                        mem_q[b][s][p] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_buf][rd_sel][rd_idx];

endmodule

// File: rtl/qkv_stream_out.sv
// qkv_stream_out: captures a parallel Q/K/V vector set on an in_valid pulse
// into a ping-pong buffer and streams it one element per beat (Q, then K,
// then V, head 0 first). A pulse finding the write entry full is dropped and
// sets the sticky overflow flag.
//   clk, rst_n : clock, async active-low reset
//   bus        : capture + streaming signals (qkv_stream_out_if.slave)
module qkv_stream_out
    import qkv_pkg::*;
#(
    parameter int PE_NUM = 12,
    parameter int DW     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    qkv_stream_out_if.slave     bus
);
    localparam int BEATS = qkv_beats(PE_NUM);
    localparam int BW    = $clog2(BEATS);
    localparam int IW    = $clog2(PE_NUM);

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [BW-1:0] K_START   = BW'(PE_NUM);
    localparam logic [BW-1:0] V_START   = BW'(2 * PE_NUM);

    logic [1:0]    full_q, full_d;
    logic          wr_buf_q, wr_buf_d;
    logic          rd_buf_q, rd_buf_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          overflow_q, overflow_d;

    logic                   in_ready, out_valid;
    logic                   capture, drop, handshake, at_last;
    logic [1:0]             sel;
    logic [BW-1:0]          idx_wide;
    logic signed [2*DW-1:0] rd_data;

    // Handshake terms come only from registered state, so in_valid and
    // out_ready never reach the status outputs combinationally.
    assign in_ready  = !full_q[wr_buf_q];
    assign out_valid = full_q[rd_buf_q];
    assign capture   = bus.in_valid && in_ready;
    assign drop      = bus.in_valid && !in_ready;
    assign handshake = out_valid && bus.out_ready;
    assign at_last   = (beat_q == LAST_BEAT);

    // beat -> (sel, idx) via range compare instead of a divider.
    always_comb begin
        sel      = SEL_Q;
        idx_wide = beat_q;
        if (beat_q >= V_START) begin
            sel      = SEL_V;
            idx_wide = beat_q - V_START;
        end else if (beat_q >= K_START) begin
            sel      = SEL_K;
            idx_wide = beat_q - K_START;
        end
    end

    always_comb begin
        full_d     = full_q;
        wr_buf_d   = wr_buf_q;
        rd_buf_d   = rd_buf_q;
        beat_d     = beat_q;
        overflow_d = overflow_q;

        if (handshake) begin
            if (at_last) begin
                beat_d           = '0;
                full_d[rd_buf_q] = 1'b0;
                rd_buf_d         = !rd_buf_q;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end

        // A capture needs its entry empty and a release needs its entry full,
        // so the two never target the same flag in one cycle.
        if (capture) begin
            full_d[wr_buf_q] = 1'b1;
            wr_buf_d         = !wr_buf_q;
        end

        // A drop wins over a simultaneous clear.
        if (drop)
            overflow_d = 1'b1;
        else if (bus.clear_ovf)
            overflow_d = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= '0;
            wr_buf_q   <= 1'b0;
            rd_buf_q   <= 1'b0;
            beat_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_buf_q   <= wr_buf_d;
            rd_buf_q   <= rd_buf_d;
            beat_q     <= beat_d;
            overflow_q <= overflow_d;
        end
    end

    qkv_pingpong_buf #(
        .PE_NUM (PE_NUM),
        .DW     (DW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (capture),
        .wr_buf  (wr_buf_q),
        .wr_q    (bus.in_q),
        .wr_k    (bus.in_k),
        .wr_v    (bus.in_v),
        .rd_buf  (rd_buf_q),
        .rd_sel  (sel),
        .rd_idx  (IW'(idx_wide)),
        .rd_data (rd_data)
    );

    // Payload is forced to zero whenever no beat is offered.
    assign bus.in_ready  = in_ready;
    assign bus.overflow  = overflow_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? rd_data : '0;
    assign bus.out_sel   = out_valid ? sel : 2'd0;
    assign bus.out_idx   = out_valid ? IW'(idx_wide) : '0;
    assign bus.out_last  = out_valid && at_last;

endmodule

// File: tb/tb_qkv_stream_out.sv
// tb_qkv_stream_out: directed self-checking bench for qkv_stream_out
// (PE_NUM = 12, DW = 4). Inputs change 1 time unit after a rising edge and
// outputs are checked at that same point, well away from the next edge.
// Data sets: set s has Q[p] = 32s+p, K[p] = 32s+16+p, V[p] = -16s-p.
module tb_qkv_stream_out;
    localparam int PE    = 12;
    localparam int DW    = 4;
    localparam int BEATS = 3 * PE;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    qkv_stream_out_if #(.PE_NUM(PE), .DW(DW)) bus ();

    qkv_stream_out #(.PE_NUM(PE), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic int exp_val(input int s, input int sel, input int idx);
        case (sel)
            0:       return 32 * s + idx;
            1:       return 32 * s + 16 + idx;
            default: return -16 * s - idx;
        endcase
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_set(input int s);
        for (int p = 0; p < PE; p++) begin
            bus.in_q[p] = 8'(exp_val(s, 0, p));
            bus.in_k[p] = 8'(exp_val(s, 1, p));
            bus.in_v[p] = 8'(exp_val(s, 2, p));
        end
    endtask

    // One-cycle capture pulse carrying set s.
    task automatic pulse(input int s);
        load_set(s);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_beat(input int s, input int b);
        check("out_valid", 32'(bus.out_valid), 1);
        check("out_sel",   32'(bus.out_sel), b / PE);
        check("out_idx",   32'(bus.out_idx), b % PE);
        check("out_data",  $signed(bus.out_data), exp_val(s, b / PE, b % PE));
        check("out_last",  32'(bus.out_last), (b == BEATS - 1) ? 1 : 0);
    endtask

    // Consume nsets buffered sets (sa, then sb) starting at the current cycle.
    // With toggle set, out_ready goes 1,0,1,0,... and each stall cycle must
    // show the unchanged beat.
    task automatic run_stream(input int sa, input int sb, input int nsets,
                              input bit toggle);
        int b   = 0;
        int cyc = 0;
        bit r;
        while (b < BEATS * nsets && cyc < 400) begin
            r = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.out_ready = r;
            check_beat((b < BEATS) ? sa : sb, b % BEATS);
            if (r) b++;
            step();
            cyc++;
        end
        check("stream_beats", b, BEATS * nsets);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset values
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.clear_ovf = 1'b0;
        bus.out_ready = 1'b0;
        load_set(0);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready",  32'(bus.in_ready), 1);
        check("rst_overflow",  32'(bus.overflow), 0);
        check("rst_out_data",  $signed(bus.out_data), 0);
        check("rst_out_last",  32'(bus.out_last), 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // 2. Single vector, no stall
        bus.out_ready = 1'b1;
        check("idle_out_valid", 32'(bus.out_valid), 0);
        pulse(0);
        run_stream(0, 0, 1, 1'b0);
        check("t2_drained", 32'(bus.out_valid), 0);
        check("t2_out_data_idle", $signed(bus.out_data), 0);
        step();

        // 3. Backpressure
        pulse(0);
        run_stream(0, 0, 1, 1'b1);
        check("t3_drained", 32'(bus.out_valid), 0);

        // 4. Ping-pong and drop
        bus.out_ready = 1'b0;
        pulse(0);
        check("t4_ready_after_a", 32'(bus.in_ready), 1);
        pulse(1);
        check("t4_ready_after_b", 32'(bus.in_ready), 0);
        check("t4_ovf_before_c", 32'(bus.overflow), 0);
        pulse(2);
        check("t4_ovf_after_c", 32'(bus.overflow), 1);
        check("t4_stall_data", $signed(bus.out_data), 0);
        run_stream(0, 1, 2, 1'b0);
        check("t4_drained", 32'(bus.out_valid), 0);
        check("t4_ovf_sticky", 32'(bus.overflow), 1);
        bus.clear_ovf = 1'b1;
        step();
        bus.clear_ovf = 1'b0;
        check("t4_ovf_cleared", 32'(bus.overflow), 0);

        // 5a. One entry full: capture coincides with last-beat handshake
        bus.out_ready = 1'b1;
        pulse(0);
        for (int b = 0; b < BEATS - 1; b++) step();
        check("t5a_last", 32'(bus.out_last), 1);
        check("t5a_in_ready", 32'(bus.in_ready), 1);
        pulse(1);
        check("t5a_ovf", 32'(bus.overflow), 0);
        run_stream(1, 1, 1, 1'b0);
        check("t5a_drained", 32'(bus.out_valid), 0);

        // 5b. Both entries full: the same coincidence drops the pulse
        bus.out_ready = 1'b0;
        pulse(0);
        pulse(1);
        bus.out_ready = 1'b1;
        for (int b = 0; b < BEATS - 1; b++) step();
        check("t5b_last", 32'(bus.out_last), 1);
        check("t5b_in_ready", 32'(bus.in_ready), 0);
        pulse(2);
        check("t5b_ovf", 32'(bus.overflow), 1);
        run_stream(1, 1, 1, 1'b0);
        check("t5b_drained", 32'(bus.out_valid), 0);
        bus.clear_ovf = 1'b1;
        step();
        bus.clear_ovf = 1'b0;

        // 6. Reset mid-stream
        pulse(0);
        for (int b = 0; b < 10; b++) step();
        check("t6_beat10_idx", 32'(bus.out_idx), 10);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.out_valid), 0);
        check("t6_rst_data",  $signed(bus.out_data), 0);
        check("t6_rst_ready", 32'(bus.in_ready), 1);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("t6_no_residual", 32'(bus.out_valid), 0);
            check("t6_in_ready", 32'(bus.in_ready), 1);
            step();
        end
        pulse(2);
        run_stream(2, 2, 1, 1'b0);
        check("t6_drained", 32'(bus.out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
